// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the synchronous count-based FIFO: drains it in bursts
// into a valid/ready stream, with a 2-entry buffer covering the FIFO's read latency.
module fifo_burst_reader #(
  parameter int DATA_W  = 3,
  parameter int ADDR_W  = 2,
  parameter int BURST   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [ADDR_W:0]   fifo_count,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int CW = ADDR_W + 1;
  localparam int LW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [LW-1:0] BURST_L = LW'(BURST);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] ZERO_L  = {LW{1'b0}};
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0] T_ZERO  = {TW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state_q;
  logic [TW-1:0]     timer_q;
  logic [LW-1:0]     remain_q;
  logic              busy_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              valid_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d;
  logic              tail_last_q, tail_last_d;

  logic credit_s;
  logic issue_s;
  logic push_s;
  logic pop_s;
  logic last_acc_s;

  // A read is only issued when the buffer can absorb it together with the one in flight.
  assign credit_s   = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
  assign issue_s    = (state_q == RD) && (remain_q != ZERO_L) && !fifo_empty && credit_s;
  assign push_s     = inflight_q;
  assign pop_s      = valid_q && m_ready;
  assign last_acc_s = pop_s && head_last_q;

  assign fifo_r_en = issue_s;
  assign m_valid   = valid_q;
  assign m_data    = head_data_q;
  assign m_last    = head_last_q;
  assign busy      = busy_q;

  // Next-state of the 2-entry output buffer (head presents, tail backs it up).
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    case ({push_s, pop_s})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_data_d = fifo_rdata;
          head_last_d = inflight_last_q;
        end else begin
          tail_data_d = fifo_rdata;
          tail_last_d = inflight_last_q;
        end
      end
      2'b01: begin
        occ_d       = occ_q - 2'd1;
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_data_d = fifo_rdata;
          head_last_d = inflight_last_q;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = fifo_rdata;
          tail_last_d = inflight_last_q;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Buffer and read-pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q           <= 2'd0;
      valid_q         <= 1'b0;
      head_data_q     <= {DATA_W{1'b0}};
      head_last_q     <= 1'b0;
      tail_data_q     <= {DATA_W{1'b0}};
      tail_last_q     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      occ_q           <= occ_d;
      valid_q         <= (occ_d != 2'd0);
      head_data_q     <= head_data_d;
      head_last_q     <= head_last_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
      inflight_q      <= issue_s;
      inflight_last_q <= issue_s && (remain_q == ONE_L);
    end
  end

  // Burst control FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= T_ZERO;
      remain_q <= ZERO_L;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_count >= BURST_C) begin
            state_q  <= RD;
            remain_q <= BURST_L;
            busy_q   <= 1'b1;
          end else if (!fifo_empty) begin
            state_q <= ARM;
            timer_q <= T_ZERO;
          end else begin
            state_q <= IDLE;
          end
        end
        ARM: begin
          if (timer_q != T_MAX) begin
            timer_q <= timer_q + TW'(1);
          end else begin
            timer_q <= timer_q;
          end
          if (fifo_count >= BURST_C) begin
            state_q  <= RD;
            remain_q <= BURST_L;
            busy_q   <= 1'b1;
          end else if (fifo_empty) begin
            state_q <= IDLE;
          end else if (timer_q == T_LAST) begin
            // Short burst: the count is below BURST here, so it fits the remain width.
            state_q  <= RD;
            remain_q <= LW'(fifo_count);
            busy_q   <= 1'b1;
          end else begin
            state_q <= ARM;
          end
        end
        RD: begin
          if (issue_s) begin
            remain_q <= remain_q - ONE_L;
            if (remain_q == ONE_L) begin
              state_q <= FIN;
            end else begin
              state_q <= RD;
            end
          end else begin
            state_q <= RD;
          end
        end
        FIN: begin
          if (last_acc_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= FIN;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a small FIFO model feeds the DUT and each
// step compares outputs against hand-derived cycle-by-cycle expectations.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [2:0] fifo_count;
  logic [2:0] fifo_rdata;
  logic       fifo_r_en;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] m_data;
  logic       m_last;
  logic       busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_W (3),
    .ADDR_W (2),
    .BURST  (2),
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .fifo_rdata(fifo_rdata),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  // Synchronous FIFO model with registered read data; not touched by DUT reset.
  logic [2:0] mem [4];
  logic [1:0] wp = 2'd0;
  logic [1:0] rp = 2'd0;
  logic [2:0] cnt = 3'd0;
  logic [2:0] rdata_r = 3'd0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_data = 3'd0;
  logic       rd_ok;

  assign rd_ok      = fifo_r_en && (cnt != 3'd0);
  assign fifo_count = cnt;
  assign fifo_empty = (cnt == 3'd0);
  assign fifo_rdata = rdata_r;

  always @(posedge clk) begin
    if (rd_ok) begin
      rdata_r <= mem[rp];
      rp      <= rp + 2'd1;
    end
    if (wr_en) begin
      mem[wp] <= wr_data;
      wp      <= wp + 2'd1;
    end
    cnt <= cnt + {2'b00, wr_en} - {2'b00, rd_ok};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted-beat log and read-while-empty monitor.
  int         ren_bad = 0;
  logic [2:0] got_d [$];
  logic       got_l [$];
  int         got_c [$];
  always @(negedge clk) begin
    if (fifo_r_en && fifo_empty) ren_bad <= ren_bad + 1;
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
      got_c.push_back(cyc);
    end
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ren, input logic v,
                            input logic [2:0] d, input logic l, input logic b);
    chk({tag, "_ren"}, {31'd0, fifo_r_en}, {31'd0, ren});
    chk({tag, "_valid"}, {31'd0, m_valid}, {31'd0, v});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    if (v) begin
      chk({tag, "_data"}, {29'd0, m_data}, {29'd0, d});
      chk({tag, "_last"}, {31'd0, m_last}, {31'd0, l});
    end
  endtask

  task automatic write(input logic [2:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Test 1 expectations for cycles 1..10 after reset release (bit i = cycle i+1).
  logic [9:0] t1_ren  = 10'b0001100011;
  logic [9:0] t1_val  = 10'b0110001100;
  logic [9:0] t1_last = 10'b0100001000;
  logic [9:0] t1_busy = 10'b0111101111;
  logic [2:0] t1_data [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 3'd4, 3'd0};

  initial begin
    int base;
    int w;
    rst     = 1'b1;
    m_ready = 1'b1;
    #2;
    rst = 1'b0;
    step();
    chk("rst_ren",   {31'd0, fifo_r_en}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data",  {29'd0, m_data}, 32'd0);
    chk("rst_last",  {31'd0, m_last}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);

    // Test 1: FIFO preloaded with 1..4 during reset, two back-to-back bursts.
    for (int i = 1; i <= 4; i++) write(3'(i));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out($sformatf("t1_c%0d", i + 1), t1_ren[i], t1_val[i], t1_data[i], t1_last[i], t1_busy[i]);
    end

    // Test 2: single entry waits out the timeout, then a 1-beat burst.
    write(3'd5);
    for (int i = 0; i < 8; i++) begin
      step();
      expect_out($sformatf("t2_arm%0d", i), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    step(); expect_out("t2_rd",   1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t2_fin",  1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t2_beat", 1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    step(); expect_out("t2_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Test 3: consumer stalls; the burst is held and then delivered in order.
    m_ready = 1'b0;
    write(3'd6);
    write(3'd1);
    step(); expect_out("t3_rd0", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t3_rd1", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("t3_hold%0d", i), 1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
    end
    m_ready = 1'b1;
    step(); expect_out("t3_b1",   1'b0, 1'b1, 3'd1, 1'b1, 1'b1);
    step(); expect_out("t3_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Test 4: reset with a beat buffered; next burst starts from the FIFO head.
    m_ready = 1'b0;
    write(3'd3);
    write(3'd4);
    write(3'd5);
    write(3'd6);
    expect_out("t4_rd", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t4_buf", 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk("t4_rst_ren",   {31'd0, fifo_r_en}, 32'd0);
    chk("t4_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_rst_data",  {29'd0, m_data}, 32'd0);
    chk("t4_rst_last",  {31'd0, m_last}, 32'd0);
    chk("t4_rst_busy",  {31'd0, busy}, 32'd0);
    step();
    step();
    rst     = 1'b1;
    m_ready = 1'b1;
    step(); expect_out("t4_rd0",  1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t4_rd1",  1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t4_b0",   1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    step(); expect_out("t4_b1",   1'b0, 1'b1, 3'd6, 1'b1, 1'b1);
    step(); expect_out("t4_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Test 5: stream 0..7 with the consumer always ready.
    base = got_d.size();
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (fifo_count == 3'd4 && w < 20) begin
        step();
        w++;
      end
      write(3'(i));
    end
    w = 0;
    while (got_d.size() < base + 8 && w < 60) begin
      step();
      w++;
    end
    chk("t5_beats", 32'(got_d.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (got_d.size() > base + i) begin
        chk($sformatf("t5_data%0d", i), {29'd0, got_d[base + i]}, 32'(i));
        chk($sformatf("t5_last%0d", i), {31'd0, got_l[base + i]}, 32'(i % 2));
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (got_c.size() > base + 2 * j + 1) begin
        chk($sformatf("t5_rate%0d", j), 32'(got_c[base + 2 * j + 1] - got_c[base + 2 * j]), 32'd1);
      end
    end
    w = 0;
    while ((busy || m_valid) && w < 10) begin
      step();
      w++;
    end
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // Test 6: count reaches BURST in ARM at timer=3 -> full burst, no timeout.
    write(3'd2);
    step();
    step();
    step();
    write(3'd5);
    expect_out("t6_t3",   1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(); expect_out("t6_rd0",  1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t6_rd1",  1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    step(); expect_out("t6_b0",   1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    step(); expect_out("t6_b1",   1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    step(); expect_out("t6_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    chk("ren_when_empty", 32'(ren_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
